// File: rtl/onehot_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_pkg
// Description : Shared constants and helper functions for the binary to
//               one-hot decoder.
//               - N_DEFAULT     : default binary index width
//               - C_MAX_N       : widest index the helpers support
//               - op_size(n)    : decoded width, 2^n
//               - onehot(en, a) : en-gated one-hot decode at maximum width
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_decoder_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int C_MAX_N       = 8;
    localparam int C_MAX_OP_SIZE = 1 << C_MAX_N;

    // Decoded output width for an n-bit index.
    function automatic int op_size(input int n);
        return 1 << n;
    endfunction

    // Decodes at the widest supported size; callers keep the low 2^N bits.
    // The index is only consulted when en is high, so an undriven index
    // cannot reach the result while decoding is disabled.
    function automatic logic [C_MAX_OP_SIZE-1:0] onehot(
        input logic               en,
        input logic [C_MAX_N-1:0] a
    );
        logic [C_MAX_OP_SIZE-1:0] v;
        v = '0;
        if (en) begin
            v[a] = 1'b1;
        end
        return v;
    endfunction

endpackage : onehot_decoder_pkg
`default_nettype wire

// File: rtl/onehot_decode_core.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decode_core
// Description : Purely combinational N-to-2^N one-hot decode with enable.
// Ports       : en  - decode enable; all outputs low when clear
//               a   - N-bit binary index
//               dec - 2^N-bit one-hot result (bit a set when en is high)
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decode_core
    import onehot_decoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                  en,
    input  logic [N-1:0]          a,
    output logic [op_size(N)-1:0] dec
);

    localparam int OP_SIZE = op_size(N);

    logic [C_MAX_N-1:0]       w_a_ext;
    logic [C_MAX_OP_SIZE-1:0] w_full;

    always_comb begin
        w_a_ext         = '0;
        w_a_ext[N-1:0]  = a;
    end

    assign w_full = onehot(en, w_a_ext);
    assign dec    = w_full[OP_SIZE-1:0];

    // Bits above 2^N can never be set because the index is zero-extended;
    // they are gathered here only so they are visibly consumed.
    generate
        if (OP_SIZE < C_MAX_OP_SIZE) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi = |w_full[C_MAX_OP_SIZE-1:OP_SIZE];
        end
    endgenerate

endmodule : onehot_decode_core
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder
// Description : Parameterised N-to-2^N binary-to-one-hot decoder with enable
//               and a registered output stage (1-cycle latency, one decode
//               per cycle).
// Parameters  : N   - index width, legal range 1..8 (output is 2^N bits)
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset, clears op
//               en       - decode enable; op registers all-zero when low
//               a        - N-bit binary index
//               op       - registered one-hot result
//               op_valid - registered copy of en (only when the build macro
//                          ONEHOT_DECODER_VALID_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder
    import onehot_decoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N-1:0]          a,
    output logic [op_size(N)-1:0] op
`ifdef ONEHOT_DECODER_VALID_EN
    ,
    output logic                  op_valid
`endif
);

    localparam int OP_SIZE = op_size(N);

    logic [OP_SIZE-1:0] w_dec;
    logic [OP_SIZE-1:0] r_op;

    onehot_decode_core #(
        .N   (N)
    ) u_core (
        .en  (en),
        .a   (a),
        .dec (w_dec)
    );

    // en and a are sampled at the same edge, so a registered result is
    // always a consistent decode of one input pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0;
        end else begin
            r_op <= w_dec;
        end
    end

    assign op = r_op;

`ifdef ONEHOT_DECODER_VALID_EN
    logic r_op_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_valid <= 1'b0;
        end else begin
            r_op_valid <= en;
        end
    end

    assign op_valid = r_op_valid;
`endif

endmodule : onehot_decoder
`default_nettype wire

// File: tb/tb_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_decoder
// Description : Self-checking bench for onehot_decoder. Drives an N=4 and an
//               N=1 instance side by side from a directed vector table,
//               sweeps and randomized cycles, comparing against an
//               arithmetic reference (1 << a, gated by en and rst).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  a;
    logic [0:0]  a1;
    logic [15:0] op;
    logic [1:0]  op1;
`ifdef ONEHOT_DECODER_VALID_EN
    logic        op_valid;
    logic        op_valid1;
`endif

    int checks = 0;
    int errors = 0;

    onehot_decoder #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
        .op       (op)
`ifdef ONEHOT_DECODER_VALID_EN
        ,
        .op_valid (op_valid)
`endif
    );

    onehot_decoder #(.N(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a1),
        .op       (op1)
`ifdef ONEHOT_DECODER_VALID_EN
        ,
        .op_valid (op_valid1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  a;
        logic [15:0] exp_op;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result of one rising edge with the given inputs.
    function automatic logic [15:0] model4(input logic r, input logic e, input logic [3:0] av);
        if (r || !e) return 16'h0000;
        return 16'(32'd1 << av);
    endfunction

    function automatic logic [1:0] model1(input logic r, input logic e, input logic av);
        if (r || !e) return 2'b00;
        return av ? 2'b10 : 2'b01;
    endfunction

    // Apply one input set, clock once, then check every output.
    task automatic apply(input logic r, input logic e, input logic [3:0] av,
                         input logic [15:0] exp_op, input string tag);
        logic exp_v;
        rst = r;
        en  = e;
        a   = av;
        a1  = av[0];
        @(posedge clk);
        #1;
        exp_v = !r && e;
        check({tag, " op"}, 32'(op), 32'(exp_op));
        check({tag, " popcount"}, 32'($countones(op)), 32'(exp_v));
        check({tag, " n1 op"}, 32'(op1), 32'(model1(r, e, av[0])));
`ifdef ONEHOT_DECODER_VALID_EN
        check({tag, " op_valid"}, 32'(op_valid), 32'(exp_v));
        check({tag, " op_valid vs op"}, 32'(op_valid), 32'(op != 16'h0000));
        check({tag, " n1 op_valid"}, 32'(op_valid1), 32'(exp_v));
`endif
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = 4'd0;
        a1  = 1'b0;

        // Directed: reset hold, release, enable toggle, mid-sequence reset.
        vecs[0]  = '{1'b1, 1'b1, 4'd3,  16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 4'd3,  16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 4'd3,  16'h0008};
        vecs[3]  = '{1'b0, 1'b1, 4'd9,  16'h0200};
        vecs[4]  = '{1'b0, 1'b0, 4'd9,  16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 4'd9,  16'h0200};
        vecs[6]  = '{1'b0, 1'b1, 4'd6,  16'h0040};
        vecs[7]  = '{1'b1, 1'b1, 4'd7,  16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 4'd8,  16'h0100};
        vecs[9]  = '{1'b0, 1'b1, 4'd15, 16'h8000};
        vecs[10] = '{1'b0, 1'b0, 4'd15, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 4'd0,  16'h0001};

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].exp_op,
                  $sformatf("vec%0d", i));
        end

        // Disabled sweep: nothing may be set.
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b0, 4'(i), 16'h0000, $sformatf("dis a=%0d", i));
        end

        // Enabled sweep: exactly bit a set one cycle later.
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b1, 4'(i), model4(1'b0, 1'b1, 4'(i)), $sformatf("en a=%0d", i));
        end

        // Randomized: en and a change together, occasional reset.
        for (int i = 0; i < 200; i++) begin
            logic       r;
            logic       e;
            logic [3:0] av;
            r  = ($urandom_range(0, 15) == 0);
            e  = 1'($urandom_range(0, 1));
            av = 4'($urandom_range(0, 15));
            apply(r, e, av, model4(r, e, av), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_onehot_decoder
`default_nettype wire
